regfile_sweep: RTL and testbench
================================

Name: regfile_sweep

Overview:
- Parametrised multi-read register file, the next generation of the 8x8 two-read/one-write register file.
- Generalised in data width and depth, with selectable hardwired-zero register 0.
- Adds asynchronous reset and a sequential bulk-clear engine that sweeps all registers to zero over DEPTH cycles, with a Busy indication.
- Sits beside the datapath ALU: feeds operands on busX/busY and takes results on busW.

Parameters:
- DATA_W, 8, register and bus width in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes; when 0 it is an ordinary register.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- WEN  input  1  write enable, sampled at rising edge.
- RW  input  ADDR_W  write address.
- busW  input  DATA_W  write data.
- RX  input  ADDR_W  read address, port X.
- RY  input  ADDR_W  read address, port Y.
- busX  output  DATA_W  read data, port X, combinational.
- busY  output  DATA_W  read data, port Y, combinational.
- Clr_req  input  1  request bulk clear, sampled at rising edge.
- Busy  output  1  registered; high while the clear sweep is in progress.

Behaviour:
- Reset (Rst_n low, asynchronous, immediate):
  - all DEPTH registers = 0; FSM = IDLE; sweep counter = 0; Busy = 0.
  - busX and busY therefore read 0.
  - Reset has priority over every other input.
- Reads:
  - busX = reg[RX] and busY = reg[RY], purely combinational, zero latency.
  - When ZERO_REG=1, address 0 always returns 0.
  - RX==RY is legal; both ports show the same value.
- Writes:
  - At a rising edge, reg[RW] <= busW when WEN=1 AND Busy=0 AND NOT (ZERO_REG=1 AND RW==0).
  - Otherwise the register file is unchanged by the write port.
  - New data is visible on the read ports after the edge (one-cycle write-to-read latency).
- Clear FSM, states IDLE and SWEEP:
  - IDLE: edge with Clr_req=1 -> SWEEP, cnt=0, Busy=1 after that edge (call it E0). Clr_req=0 -> stay in IDLE.
  - SWEEP: at each edge E1..EDEPTH, reg[cnt] <= 0 and cnt <= cnt+1.
  - At the edge where cnt==DEPTH-1: clear reg[DEPTH-1], go to IDLE, Busy=0, cnt=0.
  - Busy is high for exactly DEPTH cycles.
  - Clr_req is ignored while in SWEEP; no queueing, no restart.
- Boundary conditions:
  - WEN=1 and Clr_req=1 at the same edge in IDLE: the write is performed at E0, then cleared when the sweep reaches that address.
  - WEN=1 during SWEEP: dropped silently; the caller must watch Busy.
  - Reads during SWEEP return current contents: already-swept addresses read 0, the rest read old data.
  - Rst_n asserted mid-sweep: immediate IDLE with all registers 0 and Busy=0; the sweep is not resumed.
  - Counter is ADDR_W bits and is reset to 0 on SWEEP exit; it never wraps inside a sweep.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. When WEN=1, Busy=0, RX==RW and the target is not the hardwired zero register, busX = busW combinationally in the same cycle. busY is forwarded the same way.
- Not defined: reads always show stored contents; written data appears only after the edge.

Test Plan:
- Apply reset, sweep RX and RY over 0..7 -> busX = busY = 00000000 for every address; Busy=0.
- Write 10101010 to reg1, then 11111111 to reg7 (WEN=1) -> RX=1 gives 10101010, RY=7 gives 11111111; all other addresses read 00000000.
- Write 11001100 to reg0 -> reads 00000000 with ZERO_REG=1; reads 11001100 with ZERO_REG=0.
- WEN=0, RW=3, busW=11001100 -> reg3 still 00000000 after the edge.
- Fill regs 1..7 with 0xA5, pulse Clr_req for one cycle:
  - Busy high for exactly 8 cycles; reg k reads 0 after edge E(k+1).
  - A WEN=1 write of 0x3C to reg2 during Busy is ignored.
  - Clr_req re-pulsed at E4 has no effect.
  - After Busy falls all registers read 0.
- Mixed reset and bypass:
  - Start a sweep with regs holding 0xA5; drop Rst_n at the third Busy cycle -> Busy=0 immediately, all regs 0, next Clr_req starts a fresh 8-cycle sweep.
  - With REGFILE_BYPASS_EN defined, RX=RW=2, WEN=1, busW=0x5A -> busX=0x5A before the edge.
  - Same stimulus without the macro -> busX=0x00 until the edge.

Source files
------------

// File: rtl/regfile_sweep.sv
// regfile_sweep: parametrised two-read / one-write register file with an
// asynchronous reset and a sequential bulk-clear engine.
//
// Ports
//   Clk, Rst_n      clock (rising edge), asynchronous active-low reset
//   WEN, RW, busW   write port (enable, address, data)
//   RX, RY          read addresses; busX / busY are the combinational read data
//   Clr_req         starts a sweep that zeroes reg 0..DEPTH-1, one per cycle
//   Busy            high while the sweep runs (exactly DEPTH cycles)
//
// Parameters: DATA_W, ADDR_W (DEPTH = 2**ADDR_W), ZERO_REG (reg 0 hardwired
// to zero when 1).
//
// Build option: define REGFILE_BYPASS_EN to forward busW onto a read port in
// the same cycle when that port addresses the register being written.

// One storage register. Clear has priority, though the top never asserts
// clr and we together (writes are blocked while sweeping).
module regfile_sweep_cell #(
  parameter int DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              we,
  input  logic              clr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (we)  q <= d;
  end
endmodule

module regfile_sweep #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              WEN,
  input  logic [ADDR_W-1:0] RW,
  input  logic [DATA_W-1:0] busW,
  input  logic [ADDR_W-1:0] RX,
  input  logic [ADDR_W-1:0] RY,
  output logic [DATA_W-1:0] busX,
  output logic [DATA_W-1:0] busY,
  input  logic              Clr_req,
  output logic              Busy
);
  localparam int DEPTH = 2**ADDR_W;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;

  logic [0:0]                    state;
  logic [ADDR_W-1:0]             cnt;
  logic [DEPTH-1:0][DATA_W-1:0]  regs;
  logic                          sweeping;
  logic                          wr_ok;

  assign sweeping = (state == SWEEP);
  // Busy is the state flop itself, so it is registered with no decode glitch.
  assign Busy     = sweeping;

  // Writes are dropped during a sweep and to the hardwired zero register.
  assign wr_ok = WEN && !sweeping && !((ZERO_REG != 0) && (RW == '0));

  // Clear FSM: the counter addresses the register cleared at the next edge.
  // Leaving on cnt == all-ones means the counter never wraps inside a sweep.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (Clr_req) begin
        state <= SWEEP;
        cnt   <= '0;
      end
    end else begin
      if (cnt == '1) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + ADDR_W'(1);
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_cell
      regfile_sweep_cell #(.DATA_W(DATA_W)) u_cell (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .we    (wr_ok && (RW == ADDR_W'(i))),
        .clr   (sweeping && (cnt == ADDR_W'(i))),
        .d     (busW),
        .q     (regs[i])
      );
    end
  end

`ifdef REGFILE_BYPASS_EN
  // wr_ok already excludes Busy and the hardwired zero register.
  always_comb begin
    busX = regs[RX];
    busY = regs[RY];
    if (wr_ok && (RX == RW)) busX = busW;
    if (wr_ok && (RY == RW)) busY = busW;
  end
`else
  always_comb begin
    busX = regs[RX];
    busY = regs[RY];
  end
`endif

endmodule

// File: tb/tb_regfile_sweep.sv
// Directed bench for regfile_sweep. A second instance with ZERO_REG=0 shares
// all inputs so register 0 behaviour is checked both ways.
module tb_regfile_sweep;
  logic       Clk = 1'b0;
  logic       Rst_n, WEN, Clr_req;
  logic [2:0] RW, RX, RY;
  logic [7:0] busW, busX, busY, busX0, busY0;
  logic       Busy, Busy0;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  regfile_sweep #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .WEN(WEN), .RW(RW), .busW(busW),
    .RX(RX), .RY(RY), .busX(busX), .busY(busY),
    .Clr_req(Clr_req), .Busy(Busy)
  );

  regfile_sweep #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) dut0 (
    .Clk(Clk), .Rst_n(Rst_n), .WEN(WEN), .RW(RW), .busW(busW),
    .RX(RX), .RY(RY), .busX(busX0), .busY(busY0),
    .Clr_req(Clr_req), .Busy(Busy0)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    WEN = 1'b1; RW = a; busW = d;
    tick();
    WEN = 1'b0;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; WEN = 1'b0; Clr_req = 1'b0;
    RW = '0; busW = '0; RX = '0; RY = '0;
    #12;
    for (int a = 0; a < 8; a++) begin
      RX = 3'(a); RY = 3'(7 - a);
      #1;
      checks++;
      if (busX !== 8'h00 || busY !== 8'h00 || busX0 !== 8'h00 || busY0 !== 8'h00) begin
        errors++;
        $display("FAIL reset_read a=%0d: got %h %h %h %h expected 00", a, busX, busY, busX0, busY0);
      end
    end
    checks++;
    if (Busy !== 1'b0 || Busy0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b %b expected 0", Busy, Busy0);
    end
    @(negedge Clk) Rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    logic [7:0] exp;
    do_write(3'd1, 8'hAA);
    do_write(3'd7, 8'hFF);
    RX = 3'd1; RY = 3'd7;
    #1;
    checks++;
    if (busX !== 8'hAA || busY !== 8'hFF) begin
      errors++;
      $display("FAIL write_xy: got %h %h expected aa ff", busX, busY);
    end
    for (int a = 0; a < 8; a++) begin
      RX = 3'(a);
      #1;
      exp = (a == 1) ? 8'hAA : (a == 7) ? 8'hFF : 8'h00;
      checks++;
      if (busX !== exp || busX0 !== exp) begin
        errors++;
        $display("FAIL write_scan a=%0d: got %h %h expected %h", a, busX, busX0, exp);
      end
    end
  endtask

  task automatic test_zero_reg();
    do_write(3'd0, 8'hCC);
    RX = 3'd0; RY = 3'd0;
    #1;
    checks++;
    if (busX !== 8'h00 || busY !== 8'h00) begin
      errors++;
      $display("FAIL zero_reg_hard: got %h %h expected 00", busX, busY);
    end
    checks++;
    if (busX0 !== 8'hCC || busY0 !== 8'hCC) begin
      errors++;
      $display("FAIL zero_reg_plain: got %h %h expected cc", busX0, busY0);
    end
  endtask

  task automatic test_wen_low();
    WEN = 1'b0; RW = 3'd3; busW = 8'hCC;
    tick();
    RX = 3'd3;
    #1;
    checks++;
    if (busX !== 8'h00 || busX0 !== 8'h00) begin
      errors++;
      $display("FAIL wen_low: got %h %h expected 00", busX, busX0);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp2;
    for (int a = 0; a < 8; a++) do_write(3'(a), 8'hA5);
    Clr_req = 1'b1;
    tick();                                   // E0
    Clr_req = 1'b0;
    checks++;
    if (Busy !== 1'b1) begin
      errors++;
      $display("FAIL sweep_start: got %b expected 1", Busy);
    end
    WEN = 1'b1; RW = 3'd2; busW = 8'h3C;      // must be ignored while Busy
    for (int e = 1; e <= 8; e++) begin
      if (e == 4) Clr_req = 1'b1;             // re-pulse lands on E4
      tick();
      Clr_req = 1'b0;
      if (e == 8) WEN = 1'b0;
      RX = 3'(e - 1); RY = (e < 8) ? 3'(e) : 3'd2;
      #1;
      checks++;
      if (Busy !== (e < 8)) begin
        errors++;
        $display("FAIL sweep_busy E%0d: got %b expected %b", e, Busy, (e < 8));
      end
      checks++;
      if (busX0 !== 8'h00 || busX !== 8'h00) begin
        errors++;
        $display("FAIL sweep_cleared E%0d: got %h %h expected 00", e, busX, busX0);
      end
      if (e < 8) begin
        checks++;
        if (busY0 !== 8'hA5 || busY !== 8'hA5) begin
          errors++;
          $display("FAIL sweep_pending E%0d: got %h %h expected a5", e, busY, busY0);
        end
      end
      RX = 3'd2;
      #1;
      exp2 = (e >= 3) ? 8'h00 : 8'hA5;
      checks++;
      if (busX !== exp2) begin
        errors++;
        $display("FAIL sweep_reg2 E%0d: got %h expected %h", e, busX, exp2);
      end
    end
    tick();
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL sweep_no_restart: got %b expected 0", Busy);
    end
    for (int a = 0; a < 8; a++) begin
      RX = 3'(a); RY = 3'(a);
      #1;
      checks++;
      if (busX !== 8'h00 || busY0 !== 8'h00) begin
        errors++;
        $display("FAIL sweep_final a=%0d: got %h %h expected 00", a, busX, busY0);
      end
    end
  endtask

  task automatic test_write_with_clear();
    WEN = 1'b1; RW = 3'd5; busW = 8'h11; Clr_req = 1'b1;
    tick();                                   // E0: write happens, sweep starts
    WEN = 1'b0; Clr_req = 1'b0;
    RX = 3'd5;
    #1;
    checks++;
    if (busX !== 8'h11 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL wr_clr_e0: got %h busy=%b expected 11 busy=1", busX, Busy);
    end
    for (int e = 1; e <= 6; e++) tick();      // E6 clears reg5
    checks++;
    if (busX !== 8'h00) begin
      errors++;
      $display("FAIL wr_clr_e6: got %h expected 00", busX);
    end
    for (int i = 0; i < 10 && Busy; i++) tick();
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_clr_timeout: got busy=%b expected 0", Busy);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    for (int a = 0; a < 8; a++) do_write(3'(a), 8'hA5);
    Clr_req = 1'b1;
    tick();                                   // E0
    Clr_req = 1'b0;
    tick();                                   // E1
    tick();                                   // E2: third Busy cycle begins
    Rst_n = 1'b0;
    #1;
    checks++;
    if (Busy !== 1'b0 || Busy0 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_busy: got %b %b expected 0", Busy, Busy0);
    end
    for (int a = 0; a < 8; a++) begin
      RX = 3'(a);
      #1;
      checks++;
      if (busX !== 8'h00 || busX0 !== 8'h00) begin
        errors++;
        $display("FAIL midrst_regs a=%0d: got %h %h expected 00", a, busX, busX0);
      end
    end
    @(negedge Clk) Rst_n = 1'b1;
    Clr_req = 1'b1;
    tick();
    Clr_req = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (Busy) n++;
      tick();
    end
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL midrst_fresh_sweep: got %0d busy cycles expected 8", n);
    end
  endtask

  task automatic test_bypass();
    logic [7:0] exp_fwd, exp_fwd0;
`ifdef REGFILE_BYPASS_EN
    exp_fwd  = 8'h5A;
    exp_fwd0 = 8'h77;
`else
    exp_fwd  = 8'h00;
    exp_fwd0 = 8'h00;
`endif
    RX = 3'd2; RY = 3'd2; RW = 3'd2; busW = 8'h5A; WEN = 1'b1;
    #1;
    checks++;
    if (busX !== exp_fwd || busY !== exp_fwd) begin
      errors++;
      $display("FAIL bypass_pre_edge: got %h %h expected %h", busX, busY, exp_fwd);
    end
    tick();
    WEN = 1'b0;
    #1;
    checks++;
    if (busX !== 8'h5A) begin
      errors++;
      $display("FAIL bypass_post_edge: got %h expected 5a", busX);
    end
    RX = 3'd0; RW = 3'd0; busW = 8'h77; WEN = 1'b1;
    #1;
    checks++;
    if (busX !== 8'h00 || busX0 !== exp_fwd0) begin
      errors++;
      $display("FAIL bypass_reg0: got %h %h expected 00 %h", busX, busX0, exp_fwd0);
    end
    WEN = 1'b0;
    #1;
  endtask

  initial begin
    test_reset();
    test_write();
    test_zero_reg();
    test_wen_low();
    test_sweep();
    test_write_with_clear();
    test_reset_mid_sweep();
    test_bypass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
